// File: rtl/mfcc_window_feeder.sv
// mfcc_window_feeder: slides a K-tap window over each MFCC frame
// and presents it, with position and first/last markers, to the BNN.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/ready/data    coefficient stream in
//   in_last                final coefficient of a frame
//   win_valid/ready/data   registered K-coefficient window out
//   win_idx                window position in frame (0..NWIN-1)
//   win_first, win_last    window is first / last of its frame
//   frame_err              one-cycle pulse on a framing violation
module mfcc_window_feeder #(
  parameter int DATA_W    = 16,
  parameter int K         = 5,
  parameter int FRAME_LEN = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [K*DATA_W-1:0]   win_data,
  output logic [5:0]            win_idx,
  output logic                  win_first,
  output logic                  win_last,
  output logic                  frame_err
);

  localparam int NWIN = FRAME_LEN - K + 1;
  localparam int CW   = $clog2(FRAME_LEN);
  localparam int TW   = (K-1)*DATA_W;

  typedef enum logic {FILL, STREAM} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         s_cnt_q, s_cnt_d;
  logic [TW-1:0]         taps_q, taps_d;
  logic                  win_valid_q, win_valid_d;
  logic [K*DATA_W-1:0]   win_data_q, win_data_d;
  logic [5:0]            win_idx_q, win_idx_d;
  logic                  win_first_q, win_first_d;
  logic                  win_last_q, win_last_d;
  logic                  frame_err_q, frame_err_d;

  logic acc;
  logic last_s;
  logic early;

  // Single output slot: a new coefficient may land whenever the
  // slot is empty or is being popped this cycle.
  assign in_ready = !win_valid_q || win_ready;
  assign acc      = in_valid && in_ready;
  assign last_s   = (s_cnt_q == CW'(FRAME_LEN-1));
  assign early    = in_last && !last_s;

  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    taps_d      = taps_q;
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    win_idx_d   = win_idx_q;
    win_first_d = win_first_q;
    win_last_d  = win_last_q;
    frame_err_d = 1'b0;

    if (win_ready) begin
      win_valid_d = 1'b0;
    end

    if (acc) begin
      frame_err_d = (in_last != last_s);

      // Newest tap at the top, oldest at the bottom.
      if (early || last_s) begin
        s_cnt_d = '0;
        state_d = FILL;
        taps_d  = '0;
      end else begin
        s_cnt_d = s_cnt_q + CW'(1);
        taps_d  = {in_data, taps_q[TW-1:DATA_W]};
        unique case (state_q)
          FILL:
            if (s_cnt_q == CW'(K-2)) state_d = STREAM;
          STREAM: ;
          default: state_d = FILL;
        endcase
      end

      // An aborting sample never produces a window.
      if (state_q == STREAM && !early) begin
        win_valid_d = 1'b1;
        win_data_d  = {in_data, taps_q};
        win_idx_d   = 6'(s_cnt_q - CW'(K-1));
        win_first_d = (win_idx_d == 6'd0);
        win_last_d  = (win_idx_d == 6'(NWIN-1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      s_cnt_q     <= '0;
      taps_q      <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_idx_q   <= '0;
      win_first_q <= 1'b0;
      win_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      taps_q      <= taps_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      win_idx_q   <= win_idx_d;
      win_first_q <= win_first_d;
      win_last_q  <= win_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_idx   = win_idx_q;
  assign win_first = win_first_q;
  assign win_last  = win_last_q;
  assign frame_err = frame_err_q;

endmodule
